// File: rtl/sr_latch_driver.sv
//------------------------------------------------------------------------------
// sr_latch_driver
//
// Synchronous command front-end for a cross-coupled NAND SR latch. A single
// valid/ready command becomes one clean low pulse on exactly one of the two
// active-low latch inputs. The pulse is followed by a recovery gap. At the end
// of the gap the synchronized latch Q is compared against the commanded value.
//
// Parameters
//   PULSE_CYCLES   : cycles each low pulse is held (>= 1)
//   GAP_CYCLES     : recovery cycles before the readback check (>= 3, so the
//                    2-flop synchronizer has settled plus margin)
//   SKIP_REDUNDANT : 1 = a command whose target already equals q_state
//                    completes immediately without pulsing
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst_n      : asynchronous active-low reset
//   cmd_valid  : command present
//   cmd_set    : command target (1 = drive Q to 1, 0 = drive Q to 0)
//   cmd_ready  : command can be accepted (high only in IDLE)
//   set_n      : registered, low forces latch Q = 1
//   clr_n      : registered, low forces latch Q = 0
//   q_fb       : latch Q, asynchronous to clk
//   q_state    : q_fb after a 2-flop synchronizer
//   done       : one-cycle pulse when a command completes
//   done_skip  : one-cycle pulse with done when the command was redundant
//   err        : sticky readback-mismatch flag
//   err_clr    : synchronous clear of err (a coincident new mismatch wins)
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module sr_latch_driver #(
  parameter int unsigned PULSE_CYCLES   = 4,
  parameter int unsigned GAP_CYCLES     = 3,
  parameter bit          SKIP_REDUNDANT = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cmd_valid,
  input  logic cmd_set,
  output logic cmd_ready,
  output logic set_n,
  output logic clr_n,
  input  logic q_fb,
  output logic q_state,
  output logic done,
  output logic done_skip,
  output logic err,
  input  logic err_clr
);

  // The counter only ever holds a reload value counting down to zero, so it is
  // sized for the larger of the two phase lengths.
  localparam int unsigned CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             target;
  logic             q_meta;
  logic             accept;
  logic             redundant;

  // cmd_ready is registered and only high in IDLE, so this is a clean accept.
  assign accept    = cmd_valid && cmd_ready;
  assign redundant = SKIP_REDUNDANT && (q_state == cmd_set);

  //----------------------------------------------------------------------------
  // Two-flop synchronizer for the asynchronous latch readback.
  //----------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its source; blocking here would collapse the two stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_meta  <= 1'b0;
      q_state <= 1'b0;
    end else begin
      q_meta  <= q_fb;
      q_state <= q_meta;
    end
  end

  //----------------------------------------------------------------------------
  // Command FSM with registered outputs.
  //
  // set_n and clr_n are only ever driven low from the single target bit, one
  // through inversion and one directly, so both-low cannot be produced. Reset
  // forces both high asynchronously, which also aborts a pulse in flight.
  //----------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      target    <= 1'b0;
      set_n     <= 1'b1;
      clr_n     <= 1'b1;
      cmd_ready <= 1'b0;
      done      <= 1'b0;
      done_skip <= 1'b0;
      err       <= 1'b0;
    end else begin
      // NOTE: defaults at the top of the block make done/done_skip one-cycle
      // pulses; later assignments in the same block override them.
      done      <= 1'b0;
      done_skip <= 1'b0;

      // A mismatch assigned further down overrides this clear, so set wins.
      if (err_clr) begin
        err <= 1'b0;
      end

      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          set_n     <= 1'b1;
          clr_n     <= 1'b1;
          cnt       <= '0;
          if (accept) begin
            if (redundant) begin
              done      <= 1'b1;
              done_skip <= 1'b1;
            end else begin
              target    <= cmd_set;
              state     <= PULSE;
              cnt       <= PULSE_LOAD;
              cmd_ready <= 1'b0;
              set_n     <= !cmd_set;
              clr_n     <= cmd_set;
            end
          end
        end

        PULSE: begin
          if (cnt == '0) begin
            state <= GAP;
            cnt   <= GAP_LOAD;
            set_n <= 1'b1;
            clr_n <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        GAP: begin
          if (cnt == '0) begin
            state     <= IDLE;
            cnt       <= '0;
            done      <= 1'b1;
            cmd_ready <= 1'b1;
            if (q_state != target) begin
              err <= 1'b1;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        default: begin
          state     <= IDLE;
          cnt       <= '0;
          set_n     <= 1'b1;
          clr_n     <= 1'b1;
          cmd_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
